// File: rtl/clk_ratio_pkg.sv
// rtl/clk_ratio_pkg.sv - shared types, widths and measurement check for clk_ratio_detect
package clk_ratio_pkg;

    localparam int CNT_W   = 5;
    localparam int RATIO_W = 4;

    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [RATIO_W-1:0] ratio_t;

    localparam cnt_t TIMEOUT = 5'd16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

    // A period is plausible when it fits the ratio field and the duty cycle is within one cycle of 50%.
    function automatic logic period_ok(input cnt_t hi_len, input cnt_t lo_len);
        cnt_t sum;
        cnt_t diff;
        sum  = hi_len + lo_len;
        diff = (hi_len >= lo_len) ? (hi_len - lo_len) : (lo_len - hi_len);
        return (sum >= 5'd2) && (sum <= 5'd15) && (diff <= 5'd1);
    endfunction

endpackage

// File: rtl/clk_ratio_detect_if.sv
// rtl/clk_ratio_detect_if.sv - detector input/result bundle with master and slave views
interface clk_ratio_detect_if;
    import clk_ratio_pkg::*;

    logic   en;
    logic   div_clk;
    ratio_t ratio;
    logic   odd;
    logic   valid;
    logic   locked;
    logic   err;

    modport master (
        output en, div_clk,
        input  ratio, odd, valid, locked, err
    );

    modport slave (
        input  en, div_clk,
        output ratio, odd, valid, locked, err
    );

endinterface

// File: rtl/bit_sync.sv
// rtl/bit_sync.sv - multi-stage single-bit synchronizer, async active-low reset
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/clk_ratio_detect_fsm.sv
// rtl/clk_ratio_detect_fsm.sv - edge sampling, phase counter and measurement FSM; CLK_RATIO_DETECT_SYNC_EN adds a 2-flop input synchronizer
module clk_ratio_detect_fsm
    import clk_ratio_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    clk_ratio_detect_if.slave   bus
);

    logic s_raw;

`ifdef CLK_RATIO_DETECT_SYNC_EN
    bit_sync #(.STAGES(2)) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (bus.div_clk),
        .q_o    (s_raw)
    );
`else
    assign s_raw = bus.div_clk;
`endif

    logic s_q;
    logic s_dly_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s_q     <= 1'b0;
            s_dly_q <= 1'b0;
        end else begin
            s_q     <= s_raw;
            s_dly_q <= s_q;
        end
    end

    logic rise;
    logic fall;
    assign rise = s_q & ~s_dly_q;
    assign fall = ~s_q & s_dly_q;

    state_e state_q;
    cnt_t   cnt_q;
    cnt_t   cnt_d;
    cnt_t   high_len_q;
    logic   skip_q;
    ratio_t ratio_q;
    logic   valid_q;
    logic   locked_q;
    logic   err_q;

    cnt_t period;
    logic accept;
    logic timeout;

    always_comb begin
        cnt_d = cnt_q + 5'd1;
        if (rise || fall) begin
            cnt_d = 5'd1;
        end else if (cnt_q == TIMEOUT) begin
            cnt_d = cnt_q;
        end
    end

    assign period  = high_len_q + cnt_q;
    assign accept  = period_ok(high_len_q, cnt_q);
    assign timeout = (state_q != IDLE) && (cnt_q == TIMEOUT);

    // skip_q discards the first period after IDLE, whose high phase may be a fragment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd1;
            high_len_q <= '0;
            skip_q     <= 1'b0;
            ratio_q    <= '0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= cnt_d;
            if (!bus.en) begin
                state_q  <= IDLE;
                cnt_q    <= 5'd1;
                ratio_q  <= '0;
                locked_q <= 1'b0;
            end else if (timeout) begin
                state_q  <= IDLE;
                ratio_q  <= '0;
                locked_q <= 1'b0;
                err_q    <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (rise) begin
                            state_q <= HIGH;
                            skip_q  <= 1'b1;
                        end
                    end
                    HIGH: begin
                        if (fall) begin
                            state_q    <= LOW;
                            high_len_q <= cnt_q;
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            state_q <= HIGH;
                            if (skip_q) begin
                                skip_q <= 1'b0;
                            end else if (accept) begin
                                ratio_q  <= period[RATIO_W-1:0];
                                valid_q  <= 1'b1;
                                locked_q <= (period[RATIO_W-1:0] == ratio_q);
                            end else begin
                                err_q    <= 1'b1;
                                locked_q <= 1'b0;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.ratio  = ratio_q;
    assign bus.odd    = ratio_q[0];
    assign bus.valid  = valid_q;
    assign bus.locked = locked_q;
    assign bus.err    = err_q;

endmodule

// File: rtl/clk_ratio_detect.sv
// rtl/clk_ratio_detect.sv - top: measures the division ratio of a sampled divided clock (CLK_RATIO_DETECT_SYNC_EN selects synchronized sampling)
module clk_ratio_detect
    import clk_ratio_pkg::*;
(
    input  logic   i_ref_clk,
    input  logic   i_rst_n,
    input  logic   i_en,
    input  logic   i_div_clk,
    output ratio_t o_ratio,
    output logic   o_odd,
    output logic   o_valid,
    output logic   o_locked,
    output logic   o_err
);

    clk_ratio_detect_if bus ();

    assign bus.en      = i_en;
    assign bus.div_clk = i_div_clk;

    clk_ratio_detect_fsm u_fsm (
        .clk_i  (i_ref_clk),
        .rst_ni (i_rst_n),
        .bus    (bus)
    );

    assign o_ratio  = bus.ratio;
    assign o_odd    = bus.odd;
    assign o_valid  = bus.valid;
    assign o_locked = bus.locked;
    assign o_err    = bus.err;

endmodule

// File: tb/tb_clk_ratio_detect.sv
// tb/tb_clk_ratio_detect.sv - scoreboard bench for clk_ratio_detect with directed divider waveforms
module tb_clk_ratio_detect;

    logic clk = 1'b0;
    logic rst_n;

    clk_ratio_detect_if bus ();

    clk_ratio_detect dut (
        .i_ref_clk (clk),
        .i_rst_n   (rst_n),
        .i_en      (bus.en),
        .i_div_clk (bus.div_clk),
        .o_ratio   (bus.ratio),
        .o_odd     (bus.odd),
        .o_valid   (bus.valid),
        .o_locked  (bus.locked),
        .o_err     (bus.err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is_err;
        logic [3:0] ratio;
        logic       odd;
        logic       locked;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ratio"},  int'(bus.ratio),  0);
        check({tag, "_odd"},    int'(bus.odd),    0);
        check({tag, "_valid"},  int'(bus.valid),  0);
        check({tag, "_locked"}, int'(bus.locked), 0);
        check({tag, "_err"},    int'(bus.err),    0);
    endtask

    task automatic ev(input logic is_err, input int ratio, input logic odd, input logic locked);
        exp_t e;
        e.is_err = is_err;
        e.ratio  = 4'(ratio);
        e.odd    = odd;
        e.locked = locked;
        exp_q.push_back(e);
    endtask

    task automatic level(input logic v, input int n);
        bus.div_clk = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run(input int h, input int l, input int n);
        repeat (n) begin
            level(1'b1, h);
            level(1'b0, l);
        end
    endtask

    // Monitor: every valid or err pulse consumes one expected event.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && (bus.valid === 1'b1 || bus.err === 1'b1)) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_event: got valid=%0b err=%0b ratio=%0d, want no event",
                             bus.valid, bus.err, bus.ratio);
                end else begin
                    e = exp_q.pop_front();
                    check("ev_err",    int'(bus.err),    int'(e.is_err));
                    check("ev_valid",  int'(bus.valid),  int'(!e.is_err));
                    check("ev_ratio",  int'(bus.ratio),  int'(e.ratio));
                    check("ev_odd",    int'(bus.odd),    int'(e.odd));
                    check("ev_locked", int'(bus.locked), int'(e.locked));
                end
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        bus.en      = 1'b0;
        bus.div_clk = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        bus.en = 1'b1;
        level(1'b0, 3);

        // div-by-4: first period after IDLE discarded, lock on second accepted
        ev(0, 4, 0, 0); ev(0, 4, 0, 1);
        run(2, 2, 4);

        // div-by-5
        ev(0, 4, 0, 1); ev(0, 5, 1, 0); ev(0, 5, 1, 1);
        run(2, 3, 3);

        // lock at 6, then stuck low -> single timeout error
        ev(0, 5, 1, 1); ev(0, 6, 0, 0); ev(0, 6, 0, 1); ev(1, 0, 0, 0);
        run(3, 3, 2);
        level(1'b1, 3);
        level(1'b0, 20);

        // relock at 6 from IDLE, then switch to 3
        ev(0, 6, 0, 0); ev(0, 6, 0, 1);
        run(3, 3, 4);
        ev(0, 6, 0, 1); ev(0, 3, 1, 0); ev(0, 3, 1, 1);
        run(2, 1, 3);

        // high 4 / low 1 rejected: ratio kept, lock dropped
        ev(0, 3, 1, 1); ev(1, 3, 1, 0);
        run(4, 1, 1);
        ev(0, 3, 1, 1);
        run(2, 1, 2);

        // reset pulse mid-HIGH
        ev(0, 3, 1, 1);
        level(1'b1, 6);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("rst_mid_high");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        level(1'b1, 2);
        level(1'b0, 2);
        ev(0, 4, 0, 0); ev(0, 4, 0, 1); ev(0, 4, 0, 1);
        run(2, 2, 4);

        // enable low for 3 cycles
        ev(0, 4, 0, 1);
        level(1'b1, 4);
        bus.en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_zero("en_low");
        repeat (2) @(posedge clk);
        #1;
        bus.en = 1'b1;
        level(1'b0, 2);
        ev(0, 4, 0, 0); ev(0, 4, 0, 1);
        run(2, 2, 3);
        level(1'b1, 2);
        level(1'b0, 4);

        check("pending_events", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
